ts_switch_sequencer: RTL and testbench
======================================

// Module: ts_switch_sequencer
// PURPOSE
// Packet-aligned switchover sequencer between main_control and the 4:1 TS channel mux.
// Takes the requested channel/enable and commits the mux select only on MPEG2-TS
// packet boundaries: blanks after the old channel's packet ends, re-enables at the new
// channel's sync byte. This avoids torn packets downstream. Timeouts force progress.
// PARAMETERS
// TIMEOUT_CYC  1024  max cycles waited for a boundary in either wait state (>=2)
// MIN_DWELL    64    cycles after a commit during which new requests are held off (>=1)
// CNT_W        16    width of statistics counters
// PORTS
// clk          in   1      system clock, all logic on rising edge
// rstn         in   1      asynchronous active-low reset
// req_sel      in   2      requested channel (main_control mux_control)
// req_en       in   1      requested output enable (main_control en_mux)
// pkt_start    in   4      per-channel strobe, 1 cycle BEFORE sync byte 0x47 reaches mux
// mux_sel      out  2      committed mux select (registered)
// mux_en       out  1      committed mux output enable (registered)
// busy         out  1      1 in WAIT_OLD or WAIT_NEW
// switch_done  out  1      1-cycle pulse on every commit
// timeout      out  1      1-cycle pulse when a wait state expires
// switch_cnt   out  CNT_W  commits since reset (see CONFIGURATION)
// timeout_cnt  out  CNT_W  timeout expiries since reset (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state=IDLE, mux_sel=0, mux_en=0, busy=0, pulses=0, target=0, timer=0, counters=0.
// - Clock is clk; reset is asynchronous, active-low on rstn. A reset mid-sequence aborts it.
// - req_en=0 in any state: mux_en=0 on next edge, state->IDLE, timer cleared. mux_sel holds.
// - IDLE, mux_en=0, req_en=1: target<=req_sel, ->WAIT_NEW.
// - IDLE, mux_en=1, req_sel!=mux_sel: target<=req_sel, timer<=0, ->WAIT_OLD.
// - WAIT_OLD: target follows req_sel each cycle; if req_sel==mux_sel, ->IDLE (no pulse).
//   pkt_start[mux_sel]: mux_en<=0, timer<=0, ->WAIT_NEW.
//   The same edge with pkt_start[target] also set: commit directly.
//   timer==TIMEOUT_CYC-1: behave as boundary seen (blank, ->WAIT_NEW) plus timeout pulse.
// - WAIT_NEW: target follows req_sel (a change clears timer); mux_en stays 0.
//   pkt_start[target]: commit. timer==TIMEOUT_CYC-1: commit plus timeout pulse.
// - Commit (registered, one edge): mux_sel<=target, mux_en<=1, switch_done=1.
//   Then timer<=0, ->HOLDOFF.
// - HOLDOFF: MIN_DWELL cycles; req_sel changes ignored but not lost.
//   On exit ->IDLE, which re-evaluates req_sel. req_en=0 still overrides.
// - Latency: boundary strobe -> mux_sel/mux_en update = 1 cycle. This lands on the sync byte.
// - pkt_start bits for channels other than mux_sel/target are ignored.
// - Timer is counted with width $clog2(TIMEOUT_CYC+1). It never wraps; it is cleared on entering each wait state.
// CONFIGURATION
// TS_SWITCH_STATS_EN defined: switch_cnt increments on each switch_done.
//   timeout_cnt increments on each timeout. Both saturate at all-ones and reset to 0.
// TS_SWITCH_STATS_EN undefined: switch_cnt and timeout_cnt are tied to 0 and no counter flops are built.
//   All other behaviour is identical.
// TESTING (TIMEOUT_CYC=32, MIN_DWELL=8, TS_SWITCH_STATS_EN defined)
// 1 Start-up. Stimulus: after reset, req_en=1, req_sel=2, pulse pkt_start[2] at cycle 10.
//   Response: mux_en=0 until then, mux_sel=2 and mux_en=1 at cycle 11, switch_done pulse, switch_cnt=1.
// 2 Clean switch. Stimulus: from sel 2, req_sel=1, pkt_start[2] at t, pkt_start[1] at t+5.
//   Response: mux_en=0 at t+1, mux_sel=1 and mux_en=1 at t+6, busy high from request until t+6.
// 3 Timeouts. Stimulus: req_sel=3 with no pkt_start at all.
//   Response: blank after 32 cycles, commit to 3 after 32 more, two timeout pulses, timeout_cnt=2.
// 4 Abort and simultaneous boundary. Stimulus (a): in WAIT_OLD, req_sel returns to mux_sel.
//   Response (a): ->IDLE, mux_en stays 1, no switch_done.
//   Stimulus (b): pkt_start[old] and pkt_start[new] in the same cycle. Response (b): direct commit, mux_en never 0.
// 5 Holdoff and disable. Stimulus: change req_sel 2 cycles after a commit.
//   Response: busy stays 0 for 8 cycles, then the sequence starts.
//   Stimulus: req_en=0 in WAIT_NEW. Response: IDLE, mux_en=0, no commit.
// 6 Reset mid-sequence. Stimulus: rstn low during WAIT_NEW.
//   Response: all outputs return to their reset values immediately (asynchronous).

Source files
------------

// File: rtl/ts_switch_sequencer_if.sv
// ---------------------------------------------------------------------------
// ts_switch_sequencer_if
// Bundles the control-side request, the per-channel packet-boundary strobes
// and the committed mux controls / status of the TS switch sequencer.
//
// Signals
//   req_sel     [1:0]      requested channel (from main_control)
//   req_en                 requested output enable (from main_control)
//   pkt_start   [3:0]      per-channel strobe, one cycle before sync byte 0x47
//   mux_sel     [1:0]      committed mux select
//   mux_en                 committed mux output enable
//   busy                   high while waiting for a packet boundary
//   switch_done            one-cycle pulse on every commit
//   timeout                one-cycle pulse when a wait state expires
//   switch_cnt  [CNT_W-1:0] commits since reset
//   timeout_cnt [CNT_W-1:0] timeout expiries since reset
//
// Modports
//   master : request / strobe source, observes the committed state
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface ts_switch_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       req_sel;
    logic             req_en;
    logic [3:0]       pkt_start;
    logic [1:0]       mux_sel;
    logic             mux_en;
    logic             busy;
    logic             switch_done;
    logic             timeout;
    logic [CNT_W-1:0] switch_cnt;
    logic [CNT_W-1:0] timeout_cnt;

    modport master (
        output req_sel,
        output req_en,
        output pkt_start,
        input  mux_sel,
        input  mux_en,
        input  busy,
        input  switch_done,
        input  timeout,
        input  switch_cnt,
        input  timeout_cnt
    );

    modport slave (
        input  req_sel,
        input  req_en,
        input  pkt_start,
        output mux_sel,
        output mux_en,
        output busy,
        output switch_done,
        output timeout,
        output switch_cnt,
        output timeout_cnt
    );
endinterface

// File: rtl/ts_switch_sequencer.sv
// ---------------------------------------------------------------------------
// ts_switch_sequencer
// Packet-aligned switchover sequencer between main_control and the 4:1 TS
// channel mux. A requested channel change is committed only on MPEG2-TS packet
// boundaries: the output is blanked once the old channel's packet ends and is
// re-enabled when the new channel's sync byte arrives, so no torn packets leave
// the mux. Timeouts force progress when a channel delivers no boundaries.
//
// Parameters
//   TIMEOUT_CYC  max cycles waited for a boundary in either wait state (>=2)
//   MIN_DWELL    cycles after a commit during which new requests are held off (>=1)
//   CNT_W        width of the statistics counters
//
// Ports
//   clk    system clock, rising edge
//   rstn   asynchronous active-low reset
//   bus    ts_switch_sequencer_if.slave (request, strobes, mux controls, status)
//
// Build option
//   TS_SWITCH_STATS_EN : when defined, saturating switch/timeout counters are
//                        built; otherwise both counter outputs are tied to 0.
// ---------------------------------------------------------------------------
module ts_switch_sequencer #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int MIN_DWELL   = 64,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    ts_switch_sequencer_if.slave  bus
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam int DWL_W = (MIN_DWELL > 1) ? $clog2(MIN_DWELL + 1) : 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [DWL_W-1:0] DWL_LAST = DWL_W'(MIN_DWELL - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_OLD = 2'd1;
    localparam logic [1:0] ST_WAIT_NEW = 2'd2;
    localparam logic [1:0] ST_HOLDOFF  = 2'd3;

    logic [1:0]       state_q,  state_d;
    logic [1:0]       sel_q,    sel_d;
    logic             en_q,     en_d;
    logic [1:0]       target_q, target_d;
    logic [TMR_W-1:0] timer_q,  timer_d;
    logic [DWL_W-1:0] dwell_q,  dwell_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             tout_q,   tout_d;

    logic             old_edge_s;
    logic             new_edge_s;

    // Boundary strobes of the channel on air and of the channel being requested.
    assign old_edge_s = bus.pkt_start[sel_q];
    assign new_edge_s = bus.pkt_start[bus.req_sel];

    // Next-state logic for the switchover sequence.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        en_d     = en_q;
        target_d = target_q;
        timer_d  = timer_q;
        dwell_d  = dwell_q;
        done_d   = 1'b0;
        tout_d   = 1'b0;

        if (!bus.req_en) begin
            // Disable wins in every state; the select is left where it was.
            en_d    = 1'b0;
            state_d = ST_IDLE;
            timer_d = {TMR_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!en_q) begin
                        target_d = bus.req_sel;
                        timer_d  = {TMR_W{1'b0}};
                        state_d  = ST_WAIT_NEW;
                    end else if (bus.req_sel != sel_q) begin
                        target_d = bus.req_sel;
                        timer_d  = {TMR_W{1'b0}};
                        state_d  = ST_WAIT_OLD;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end

                ST_WAIT_OLD: begin
                    target_d = bus.req_sel;
                    if (bus.req_sel == sel_q) begin
                        // Request withdrawn before anything changed on air.
                        state_d = ST_IDLE;
                    end else if (old_edge_s && new_edge_s) begin
                        // Both packets align on this edge: no blanking needed.
                        done_d = 1'b1;
                    end else if (old_edge_s || (timer_q == TMR_LAST)) begin
                        en_d    = 1'b0;
                        timer_d = {TMR_W{1'b0}};
                        tout_d  = !old_edge_s;
                        state_d = ST_WAIT_NEW;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end

                ST_WAIT_NEW: begin
                    if (new_edge_s) begin
                        target_d = bus.req_sel;
                        done_d   = 1'b1;
                    end else if (bus.req_sel != target_q) begin
                        // Retarget: the new channel gets a full timeout window.
                        target_d = bus.req_sel;
                        timer_d  = {TMR_W{1'b0}};
                    end else if (timer_q == TMR_LAST) begin
                        done_d   = 1'b1;
                        tout_d   = 1'b1;
                    end else begin
                        timer_d  = timer_q + TMR_W'(1);
                    end
                end

                ST_HOLDOFF: begin
                    if (dwell_q == DWL_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        dwell_d = dwell_q + DWL_W'(1);
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (done_d) begin
            sel_d   = target_d;
            en_d    = 1'b1;
            timer_d = {TMR_W{1'b0}};
            dwell_d = {DWL_W{1'b0}};
            state_d = ST_HOLDOFF;
        end else begin
            sel_d   = sel_d;
        end

        busy_d = (state_d == ST_WAIT_OLD) || (state_d == ST_WAIT_NEW);
    end

    // State, committed mux controls and status pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            sel_q    <= 2'd0;
            en_q     <= 1'b0;
            target_q <= 2'd0;
            timer_q  <= {TMR_W{1'b0}};
            dwell_q  <= {DWL_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            en_q     <= en_d;
            target_q <= target_d;
            timer_q  <= timer_d;
            dwell_q  <= dwell_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tout_q   <= tout_d;
        end
    end

    assign bus.mux_sel     = sel_q;
    assign bus.mux_en      = en_q;
    assign bus.busy        = busy_q;
    assign bus.switch_done = done_q;
    assign bus.timeout     = tout_q;

`ifdef TS_SWITCH_STATS_EN
    logic [CNT_W-1:0] swc_q;
    logic [CNT_W-1:0] toc_q;

    // Saturating commit and timeout counters, driven by the registered pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            swc_q <= {CNT_W{1'b0}};
            toc_q <= {CNT_W{1'b0}};
        end else begin
            if (done_q && (swc_q != {CNT_W{1'b1}})) begin
                swc_q <= swc_q + CNT_W'(1);
            end else begin
                swc_q <= swc_q;
            end
            if (tout_q && (toc_q != {CNT_W{1'b1}})) begin
                toc_q <= toc_q + CNT_W'(1);
            end else begin
                toc_q <= toc_q;
            end
        end
    end

    assign bus.switch_cnt  = swc_q;
    assign bus.timeout_cnt = toc_q;
`else
    assign bus.switch_cnt  = {CNT_W{1'b0}};
    assign bus.timeout_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ts_switch_sequencer.sv
module tb_ts_switch_sequencer;

    localparam int TO    = 32;
    localparam int MD    = 8;
    localparam int CW    = 16;
`ifdef TS_SWITCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic rstn;

    ts_switch_sequencer_if #(.CNT_W(CW)) bus ();

    ts_switch_sequencer #(
        .TIMEOUT_CYC (TO),
        .MIN_DWELL   (MD),
        .CNT_W       (CW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: what the outside world should see, tracked by phase.
    // phase: 0 steady, 1 waiting for old packet end, 2 waiting for new sync, 3 dwell
    int       m_phase;
    int       m_sel, m_en, m_tgt;
    int       m_waited;     // cycles spent in the current wait window
    int       m_dwelt;      // cycles spent in dwell
    int       m_busy, m_done, m_to;
    int       m_swc, m_toc;

    task automatic model_reset();
        m_phase = 0; m_sel = 0; m_en = 0; m_tgt = 0;
        m_waited = 0; m_dwelt = 0;
        m_busy = 0; m_done = 0; m_to = 0; m_swc = 0; m_toc = 0;
    endtask

    task automatic model_edge(input int sel, input int en, input logic [3:0] ps);
        bit commit = 1'b0;
        bit expire = 1'b0;
        int nxt = m_phase;
        if (en == 0) begin
            m_en = 0; nxt = 0; m_waited = 0;
        end else if (m_phase == 0) begin
            if (m_en == 0) begin
                m_tgt = sel; m_waited = 0; nxt = 2;
            end else if (sel != m_sel) begin
                m_tgt = sel; m_waited = 0; nxt = 1;
            end
        end else if (m_phase == 1) begin
            m_tgt = sel;
            if (sel == m_sel)                 nxt = 0;
            else if (ps[m_sel] && ps[sel])    commit = 1'b1;
            else if (ps[m_sel]) begin         m_en = 0; m_waited = 0; nxt = 2; end
            else if (m_waited + 1 == TO) begin m_en = 0; m_waited = 0; nxt = 2; expire = 1'b1; end
            else                              m_waited++;
        end else if (m_phase == 2) begin
            if (ps[sel]) begin               m_tgt = sel; commit = 1'b1; end
            else if (sel != m_tgt) begin     m_tgt = sel; m_waited = 0; end
            else if (m_waited + 1 == TO) begin commit = 1'b1; expire = 1'b1; end
            else                             m_waited++;
        end else begin
            if (m_dwelt + 1 == MD) nxt = 0;
            else                   m_dwelt++;
        end
        if (commit) begin
            m_sel = m_tgt; m_en = 1; m_waited = 0; m_dwelt = 0; nxt = 3;
        end
        m_phase = nxt;
        // Counters follow the registered pulses, so they lag them by one edge.
        if (STATS && m_done == 1 && m_swc < (1 << CW) - 1) m_swc++;
        if (STATS && m_to   == 1 && m_toc < (1 << CW) - 1) m_toc++;
        m_done = commit;
        m_to   = expire;
        m_busy = (nxt == 1 || nxt == 2) ? 1 : 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("mux_sel",     {30'd0, bus.mux_sel},     m_sel);
        chk("mux_en",      {31'd0, bus.mux_en},      m_en);
        chk("busy",        {31'd0, bus.busy},        m_busy);
        chk("switch_done", {31'd0, bus.switch_done}, m_done);
        chk("timeout",     {31'd0, bus.timeout},     m_to);
        chk("switch_cnt",  {16'd0, bus.switch_cnt},  m_swc);
        chk("timeout_cnt", {16'd0, bus.timeout_cnt}, m_toc);
    endtask

    int to_seen;
    int en_low_seen;

    // One clock: model consumes the inputs present at the edge, DUT sampled #1 later.
    task automatic tick();
        model_edge(int'(bus.req_sel), int'(bus.req_en), bus.pkt_start);
        @(posedge clk);
        #1;
        if (bus.timeout === 1'b1) to_seen++;
        if (bus.mux_en === 1'b0) en_low_seen++;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_sel"},  {30'd0, bus.mux_sel},     32'd0);
        chk({tag, "_en"},   {31'd0, bus.mux_en},      32'd0);
        chk({tag, "_busy"}, {31'd0, bus.busy},        32'd0);
        chk({tag, "_done"}, {31'd0, bus.switch_done}, 32'd0);
        chk({tag, "_to"},   {31'd0, bus.timeout},     32'd0);
        chk({tag, "_swc"},  {16'd0, bus.switch_cnt},  32'd0);
        chk({tag, "_toc"},  {16'd0, bus.timeout_cnt}, 32'd0);
    endtask

    initial begin
        rstn          = 1'b0;
        bus.req_sel   = 2'd0;
        bus.req_en    = 1'b0;
        bus.pkt_start = 4'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        #5 rstn = 1'b1;

        // 1: start-up, sync of channel 2 arrives on cycle 10
        bus.req_en = 1'b1; bus.req_sel = 2'd2;
        ticks(10);
        chk("t1_en_before", {31'd0, bus.mux_en}, 32'd0);
        bus.pkt_start = 4'b0100; tick(); bus.pkt_start = 4'b0000;
        chk("t1_sel", {30'd0, bus.mux_sel}, 32'd2);
        chk("t1_en", {31'd0, bus.mux_en}, 32'd1);
        chk("t1_done", {31'd0, bus.switch_done}, 32'd1);
        ticks(MD + 1);
        chk("t1_cnt", {16'd0, bus.switch_cnt}, STATS ? 32'd1 : 32'd0);

        // 2: clean switch 2 -> 1
        bus.req_sel = 2'd1;
        ticks(3);
        chk("t2_busy", {31'd0, bus.busy}, 32'd1);
        bus.pkt_start = 4'b0100; tick(); bus.pkt_start = 4'b0000;
        chk("t2_blank", {31'd0, bus.mux_en}, 32'd0);
        ticks(4);
        bus.pkt_start = 4'b0010; tick(); bus.pkt_start = 4'b0000;
        chk("t2_sel", {30'd0, bus.mux_sel}, 32'd1);
        chk("t2_en", {31'd0, bus.mux_en}, 32'd1);
        ticks(MD + 1);

        // 3: no boundaries at all, both waits expire
        to_seen = 0;
        bus.req_sel = 2'd3;
        ticks(2 * TO + 4);
        chk("t3_pulses", to_seen, 32'd2);
        chk("t3_sel", {30'd0, bus.mux_sel}, 32'd3);
        ticks(MD);

        // 4a: request withdrawn while waiting for the old packet
        bus.req_sel = 2'd0;
        ticks(5);
        chk("t4a_busy", {31'd0, bus.busy}, 32'd1);
        bus.req_sel = 2'd3;
        tick();
        chk("t4a_idle", {31'd0, bus.busy}, 32'd0);
        chk("t4a_en", {31'd0, bus.mux_en}, 32'd1);
        ticks(3);

        // 4b: old and new boundary on the same edge -> direct commit
        en_low_seen = 0;
        bus.req_sel = 2'd0;
        ticks(3);
        bus.pkt_start = 4'b1001; tick(); bus.pkt_start = 4'b0000;
        chk("t4b_sel", {30'd0, bus.mux_sel}, 32'd0);
        chk("t4b_never_blank", en_low_seen, 32'd0);

        // 5: request during holdoff is deferred, not dropped
        tick(); tick();
        bus.req_sel = 2'd1;
        ticks(6);
        chk("t5_held", {31'd0, bus.busy}, 32'd0);
        tick();
        chk("t5_started", {31'd0, bus.busy}, 32'd1);
        bus.pkt_start = 4'b0001; tick(); bus.pkt_start = 4'b0000;
        ticks(2);
        bus.req_en = 1'b0; tick();
        chk("t5_dis_en", {31'd0, bus.mux_en}, 32'd0);
        chk("t5_dis_busy", {31'd0, bus.busy}, 32'd0);
        ticks(3);

        // 6: asynchronous reset while waiting for a new sync
        bus.req_en = 1'b1; bus.req_sel = 2'd2;
        ticks(3);
        #2 rstn = 1'b0;
        #1 check_reset_values("t6");
        model_reset();
        #2 rstn = 1'b1;
        ticks(4);

        // Randomised traffic: alternate dense-boundary and silent stretches
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) bus.req_sel = 2'($urandom_range(0, 3));
            bus.req_en = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            if (((i / 300) % 2) == 0) begin
                for (int b = 0; b < 4; b++) bus.pkt_start[b] = ($urandom_range(0, 9) == 0);
            end else begin
                bus.pkt_start = 4'b0000;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
